// File: rtl/item_memory_fetcher_if.sv
// Address and hypervector valid/ready streams of the item memory fetcher.
// The DUT takes the slave view; the address source and consumer take master.
interface item_memory_fetcher_if #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned ImAddrWidth = 10
);

  logic [ImAddrWidth-1:0] addr_i;
  logic                   addr_valid_i;
  logic                   addr_ready_o;
  logic [HVDimension-1:0] hv_o;
  logic                   hv_valid_o;
  logic                   hv_last_o;
  logic                   hv_ready_i;

  modport master (
    output addr_i,
    output addr_valid_i,
    output hv_ready_i,
    input  addr_ready_o,
    input  hv_o,
    input  hv_valid_o,
    input  hv_last_o
  );

  modport slave (
    input  addr_i,
    input  addr_valid_i,
    input  hv_ready_i,
    output addr_ready_o,
    output hv_o,
    output hv_valid_o,
    output hv_last_o
  );

endinterface

// File: rtl/item_memory_fetcher.sv
// Item memory fetcher: address in, 1-cycle memory read, 2-entry hv buffer out.
// Define ITEM_MEM_FETCH_PERF_EN to build the saturating perf counters.
module item_memory_fetcher #(
  parameter  int unsigned HVDimension  = 512,
  parameter  int unsigned NumTotIm     = 1024,
  parameter  int unsigned CsrDataWidth = 32,
  localparam int unsigned ImAddrWidth  = $clog2(NumTotIm)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic [CsrDataWidth-1:0] csr_elem_size_i,
  item_memory_fetcher_if.slave    bus,
  output logic                    im_rd_en_o,
  output logic [ImAddrWidth-1:0]  im_rd_addr_o,
  input  logic [HVDimension-1:0]  im_rd_data_i,
  output logic [31:0]             perf_fetch_cnt_o,
  output logic [31:0]             perf_stall_cnt_o
);

  typedef struct packed {
    logic                   last;
    logic [HVDimension-1:0] hv;
  } entry_t;

  entry_t      buf_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  occ_q;
  logic        infl_q;
  logic        infl_last_q;
  logic [31:0] elem_cnt_q;

  logic [31:0] size_eff;
  logic [1:0]  credit;
  logic        fire;
  logic        pop;
  logic        push;
  logic        tag_last;

  assign size_eff = (csr_elem_size_i == '0) ? 32'd1
                                            : 32'(csr_elem_size_i);
  assign tag_last = (elem_cnt_q == size_eff - 32'd1);

  assign pop    = bus.hv_valid_o & bus.hv_ready_i & ~clr_i;
  assign push   = infl_q & ~clr_i;
  assign credit = occ_q + {1'b0, infl_q};

  // A pop this cycle frees the slot the new read will land in two cycles on
  assign bus.addr_ready_o = ~rst_i & enable_i & ~clr_i &
                            ((credit < 2'd2) |
                             ((credit == 2'd2) & pop));

  assign fire         = bus.addr_valid_i & bus.addr_ready_o;
  assign im_rd_en_o   = fire;
  assign im_rd_addr_o = bus.addr_i;

  assign bus.hv_valid_o = (occ_q != 2'd0);
  assign bus.hv_o       = buf_q[rd_ptr_q].hv;
  assign bus.hv_last_o  = buf_q[rd_ptr_q].last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      elem_cnt_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      elem_cnt_q  <= '0;
    end else begin
      infl_q      <= fire;
      infl_last_q <= tag_last;
      if (push) begin
        buf_q[wr_ptr_q] <= '{last: infl_last_q, hv: im_rd_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(push) - 2'(pop);
      if (!enable_i) begin
        elem_cnt_q <= '0;
      end else if (fire) begin
        elem_cnt_q <= tag_last ? '0 : elem_cnt_q + 32'd1;
      end
    end
  end

`ifdef ITEM_MEM_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = bus.hv_valid_o & ~bus.hv_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (clr_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && !(&fetch_cnt_q)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_fetch_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule
